// File: rtl/adder_tree_mult_pipe.sv
// Pipelined shift-and-add multiplier: W partial products reduced by a registered binary adder tree.
// Define MULT_SIGNED_EN to add the in_signed port for per-transaction two's-complement operation.
module adder_tree_mult_pipe #(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
`ifdef MULT_SIGNED_EN
  input  logic             in_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic             busy
);

  localparam int unsigned LOG2W = $clog2(W);
  localparam int unsigned LAT   = LOG2W + 2;
  localparam int unsigned PW    = 2 * W;

  // Heap-ordered tree: node[1] is the root, node[W..2W-1] hold the stage-1 partial products.
  logic [PW-1:0]  node [1:2*W-1];
  logic [PW-1:0]  pp   [0:W-1];
  logic [PW-1:0]  ext;
  logic [LAT-2:0] vld;
  logic           sgn;
  logic           advance;

`ifdef MULT_SIGNED_EN
  assign sgn = in_signed;
`else
  assign sgn = 1'b0;
`endif

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign busy     = (|vld) || out_valid;

  // Partial products; in signed mode the MSB row carries negative weight.
  always_comb begin
    ext = {{W{sgn & in_a[W-1]}}, in_a};
    for (int i = 0; i < int'(W); i++) begin
      pp[i] = '0;
      if (in_b[i]) begin
        if (sgn && (i == int'(W) - 1)) pp[i] = PW'(-(ext << i));
        else                           pp[i] = PW'(ext << i);
      end
    end
  end

  // Whole pipeline moves together on advance and freezes otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld       <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      for (int k = 1; k < 2 * int'(W); k++) node[k] <= '0;
    end else if (advance) begin
      vld <= {vld[LAT-3:0], in_valid};
      for (int i = 0; i < int'(W); i++) node[int'(W) + i] <= pp[i];
      for (int k = 1; k < int'(W); k++) node[k] <= node[2*k] + node[2*k+1];
      out_valid <= vld[LAT-2];
      out_p     <= node[1];
    end
  end

endmodule

// File: tb/tb_adder_tree_mult_pipe.sv
// Randomised self-checking bench for adder_tree_mult_pipe (W=8) with a slot-level reference model.
module tb_adder_tree_mult_pipe;

  localparam int unsigned W   = 8;
  localparam int unsigned LAT = $clog2(W) + 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int delivered = 0;

  adder_tree_mult_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef MULT_SIGNED_EN
    .in_signed (in_signed),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    logic signed [2*W-1:0] sa, sb;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return (2*W)'(sa * sb);
    end
    return (2*W)'(a) * (2*W)'(b);
  endfunction

  function automatic logic rnd_sign();
`ifdef MULT_SIGNED_EN
    return 1'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  // Model: LAT slots that all move one place on advance; the last slot is the output register.
  logic           mv [LAT];
  logic [2*W-1:0] mp [LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < int'(LAT); j++) begin mv[j] = 1'b0; mp[j] = '0; end
    end else if (!mv[LAT-1] || out_ready) begin
      for (int j = int'(LAT) - 1; j > 0; j--) begin mv[j] = mv[j-1]; mp[j] = mp[j-1]; end
      mv[0] = in_valid;
      mp[0] = ref_mul(in_a, in_b, in_signed);
    end
  end

  // Compare process, mid-cycle.
  always @(negedge clk) begin
    logic any;
    any = 1'b0;
    for (int j = 0; j < int'(LAT); j++) any = any | mv[j];
    chk("in_ready", 64'(in_ready), 64'(!mv[LAT-1] || out_ready));
    chk("out_valid", 64'(out_valid), 64'(mv[LAT-1]));
    chk("busy", 64'(busy), 64'(any));
    if (mv[LAT-1]) chk("out_p", 64'(out_p), 64'(mp[LAT-1]));
    if (rst_n && in_valid && in_ready) accepted++;
    if (rst_n && out_valid && out_ready) delivered++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single transaction into an empty pipe; checks latency and a hand-computed product.
  task automatic lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic s, input logic [2*W-1:0] req);
    int n;
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin step(); n++; end
    chk({name, "_lat"}, 64'(n), 64'(LAT));
    chk(name, 64'(out_p), 64'(req));
    repeat (3) step();
  endtask

  task automatic drive_rand(input logic v);
    in_valid = v; in_a = W'($urandom); in_b = W'($urandom); in_signed = rnd_sign();
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_p", 64'(out_p), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    step();

    lit("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    lit("u_80_80", 8'h80, 8'h80, 1'b0, 16'h4000);
    lit("u_ff_01", 8'hFF, 8'h01, 1'b0, 16'h00FF);
    lit("u_7f_80", 8'h7F, 8'h80, 1'b0, 16'h3F80);
    lit("u_00_ff", 8'h00, 8'hFF, 1'b0, 16'h0000);
`ifdef MULT_SIGNED_EN
    lit("s_80_80", 8'h80, 8'h80, 1'b1, 16'h4000);
    lit("s_ff_01", 8'hFF, 8'h01, 1'b1, 16'hFFFF);
    lit("s_7f_80", 8'h7F, 8'h80, 1'b1, 16'hC080);
    lit("s_ff_ff", 8'hFF, 8'hFF, 1'b1, 16'h0001);
`endif

    // Back-to-back stream with out_ready held high.
    d0 = delivered;
    for (int i = 0; i < 20; i++) begin drive_rand(1'b1); step(); end
    in_valid = 1'b0;
    repeat (LAT + 2) step();
    chk("stream_count", 64'(delivered - d0), 64'd20);

    // Stream with a 10-cycle downstream stall in the middle.
    for (int i = 0; i < 30; i++) begin
      drive_rand(1'b1);
      out_ready = !(i >= 8 && i < 18);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (LAT + 2) step();
    chk("bp_no_loss", 64'(accepted), 64'(delivered));

    // Alternating bubbles.
    for (int i = 0; i < 16; i++) begin drive_rand(1'((i + 1) % 2)); step(); end
    in_valid = 1'b0;
    repeat (LAT + 2) step();

    // Random valid/ready traffic.
    for (int i = 0; i < 300; i++) begin
      drive_rand(1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (LAT + 2) step();
    chk("rand_no_loss", 64'(accepted), 64'(delivered));

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) begin drive_rand(1'b1); step(); end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_out_p", 64'(out_p), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    accepted = 0; delivered = 0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (LAT + 3) step();
    chk("post_rst_no_stale", 64'(delivered), 64'd0);
    lit("post_rst", 8'h12, 8'h34, 1'b0, 16'h03A8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_tree_mult_pipe.md
ADDER_TREE_MULT_PIPE -- requirements
Module: adder_tree_mult_pipe

Interface
REQ-001 SHALL have parameter W, default 8, meaning operand width; legal values 4, 8, 16, 32 (power of two).
REQ-002 SHALL have parameter LAT, derived as log2(W)+2, meaning fixed input-to-output latency in advancing cycles; not overridable.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 in_a  input  W  multiplicand.
REQ-008 in_b  input  W  multiplier; bit i selects partial product i.
REQ-009 in_signed  input  1  two's-complement mode for this transaction; present only with MULT_SIGNED_EN.
REQ-010 out_valid  output  1  out_p holds a product.
REQ-011 out_ready  input  1  downstream accepts out_p.
REQ-012 out_p  output  2W  product.
REQ-013 busy  output  1  any pipeline stage holds a valid transaction.

Function
REQ-014 SHALL form W partial products in stage 1: pp[i] = in_b[i] ? in_a extended to 2W bits : 0, pre-shifted left by i.
REQ-015 SHALL reduce the W partial products with a binary adder tree, one registered level per stage: log2(W) levels, each level halving the operand count.
REQ-016 SHALL register the tree root into out_p, for total latency LAT (W=8 -> 5 cycles) when unstalled.
REQ-017 SHALL carry a per-stage valid bit alongside data, so every stage's valid is the exact transaction marker; no sticky valid bits.
REQ-018 SHALL define advance = !out_valid | out_ready, and SHALL assert in_ready = advance.
REQ-019 When advance=1, every stage SHALL load from its predecessor, and stage 1 SHALL capture its inputs with valid = in_valid.
REQ-020 When advance=0, all stage data and valids SHALL hold unchanged; bubbles are not collapsed.
REQ-021 A transaction SHALL be accepted only when in_valid & in_ready are both high in the same cycle.
REQ-022 A transaction SHALL be delivered only when out_valid & out_ready are both high in the same cycle; out_p SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 Simultaneous accept and deliver in one cycle SHALL be legal, sustaining one product per cycle.
REQ-024 Unsigned mode SHALL produce out_p = in_a*in_b exactly; 2W bits never overflow.
REQ-025 busy SHALL be the OR of all stage valids, including out_valid.

Reset
REQ-026 rst_n low SHALL asynchronously clear all stage valids, out_valid, busy, and out_p (all to 0); in-flight transactions are discarded.
REQ-027 in_ready SHALL be 1 during and after reset, because out_valid=0.
REQ-028 After rst_n deasserts, the first accepted transaction SHALL appear LAT cycles later with no residue from pre-reset data.

Configuration
REQ-029 Macro MULT_SIGNED_EN SHALL control signed support.
REQ-030 With MULT_SIGNED_EN defined:
- in_signed SHALL exist and SHALL be registered with stage 1.
- When in_signed=1, in_a SHALL be sign-extended to 2W bits and pp[W-1] SHALL be negated (two's complement), giving out_p = signed(in_a)*signed(in_b) in 2W-bit two's complement.
- When in_signed=0, behaviour SHALL match unsigned mode.
REQ-031 Without MULT_SIGNED_EN, the in_signed port and its logic SHALL be absent, and all transactions SHALL be unsigned.

Verification (W=8)
REQ-032 Unsigned: in_a=255, in_b=255, out_ready=1 held -> out_valid 5 cycles after accept, out_p=0xFE01.
REQ-033 Streaming: 20 back-to-back random pairs, out_ready=1 -> 20 consecutive out_valid cycles, every product correct, in_ready never low.
REQ-034 Backpressure: out_ready=0 for 10 cycles mid-stream -> in_ready=0 once out_valid=1; out_p stable; no loss or duplication after release.
REQ-035 Signed (MULT_SIGNED_EN): in_signed=1 with
- 0x80 x 0x80 -> 0x4000;
- 0xFF x 0x01 -> 0xFFFF;
- 0x7F x 0x80 -> 0xC080.
REQ-036 Reset mid-operation: assert rst_n with 3 transactions in flight -> out_valid=0, busy=0, out_p=0 immediately; no stale output after release.
REQ-037 Bubbles: alternate in_valid 1/0 -> out_valid alternates 1/0 at LAT delay, with products in order.
